// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vend_ctrl
//  Purpose  : Multi-item vending controller with credit, per-item stock and
//             change datapath. Accepts valued coins, an item selection and a
//             cancel request. Holds credit up to MAX_CREDIT, dispenses the
//             selected item and returns change as a single-cycle pulse.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             coin_valid, coin_val    - coin presented this cycle and its value
//             sel_valid, sel          - item selection request and index
//             cancel                  - return all credit
//             restock                 - reload every stock counter
//             prices                  - packed price table, item i at [i*VAL_W +: VAL_W]
//             credit                  - current credit
//             coin_rej                - coin rejected this cycle
//             disp, disp_item         - dispense pulse and item index
//             chg_valid, chg_amt      - change pulse and amount (0 when idle)
//             err_insuf, err_empty    - selection refused (credit / sold out)
//             sold_out                - bit i set when item i has no stock
//             busy                    - controller not in its idle WAIT state
//  Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl #(
    parameter int VAL_W      = 8,
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
    parameter int MAX_CREDIT = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     coin_valid,
    input  logic [VAL_W-1:0]         coin_val,
    input  logic                     sel_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     cancel,
    input  logic                     restock,
    input  logic [N_ITEMS*VAL_W-1:0] prices,
    output logic [VAL_W-1:0]         credit,
    output logic                     coin_rej,
    output logic                     disp,
    output logic [SEL_W-1:0]         disp_item,
    output logic                     chg_valid,
    output logic [VAL_W-1:0]         chg_amt,
    output logic                     err_insuf,
    output logic                     err_empty,
    output logic [N_ITEMS-1:0]       sold_out,
    output logic                     busy
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ADD    = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DISP   = 3'd4,
        ST_CHANGE = 3'd5
    } state_t;

    localparam logic [VAL_W:0]     c_max_credit = (VAL_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0] c_stock_init = STOCK_W'(STOCK_INIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VAL_W-1:0]   r_credit;
    logic [VAL_W-1:0]   r_coin;
    logic [SEL_W-1:0]   r_sel;
    logic [STOCK_W-1:0] r_stock [N_ITEMS];

    logic [VAL_W-1:0]   w_price_arr [N_ITEMS];
    logic [VAL_W-1:0]   w_price;
    logic [VAL_W:0]     w_sum;
    logic               w_over;
    logic               w_empty;
    logic               w_insuf;
    logic               w_sel_ok;
    logic               w_take_coin;
    logic               w_take_sel;

    generate
        for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_item
            assign w_price_arr[gi] = prices[gi*VAL_W +: VAL_W];
            assign sold_out[gi]    = (r_stock[gi] == '0);
        end
    endgenerate

    assign w_price = w_price_arr[r_sel];

    // One extra bit so the ceiling test cannot be fooled by wrap-around.
    assign w_sum   = {1'b0, r_credit} + {1'b0, r_coin};
    assign w_over  = (w_sum > c_max_credit);
    assign w_empty = (r_stock[r_sel] == '0);
    assign w_insuf = (r_credit < w_price);

    // WAIT request decode, priority cancel > coin > selection.
    assign w_sel_ok    = (int'(sel) < N_ITEMS);
    assign w_take_coin = !cancel && coin_valid;
    assign w_take_sel  = !cancel && !coin_valid && sel_valid && w_sel_ok;

    assign credit = r_credit;
    assign busy   = (r_state != ST_WAIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        coin_rej    = 1'b0;
        disp        = 1'b0;
        disp_item   = '0;
        chg_valid   = 1'b0;
        chg_amt     = '0;
        err_insuf   = 1'b0;
        err_empty   = 1'b0;

        case (r_state)
            ST_INIT: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (cancel) begin
                    if (r_credit != '0) begin
                        w_state_nxt = ST_CHANGE;
                    end
                end else if (w_take_coin) begin
                    w_state_nxt = ST_ADD;
                end else if (w_take_sel) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_ADD: begin
                coin_rej    = w_over;
                w_state_nxt = ST_WAIT;
            end
            ST_CHECK: begin
                if (w_empty) begin
                    err_empty   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else if (w_insuf) begin
                    err_insuf   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_DISP;
                end
            end
            ST_DISP: begin
                disp        = 1'b1;
                disp_item   = r_sel;
                // Any remainder after paying goes back as change.
                w_state_nxt = (r_credit != w_price) ? ST_CHANGE : ST_INIT;
            end
            ST_CHANGE: begin
                chg_valid   = 1'b1;
                chg_amt     = r_credit;
                w_state_nxt = ST_INIT;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase

        // A coin that arrives while the controller is occupied is bounced.
        if (coin_valid && (r_state != ST_WAIT)) begin
            coin_rej = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Credit, latched coin and latched selection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= '0;
            r_coin   <= '0;
            r_sel    <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_credit <= '0;
                end
                ST_WAIT: begin
                    if (w_take_coin) begin
                        r_coin <= coin_val;
                    end
                    if (w_take_sel) begin
                        r_sel <= sel;
                    end
                end
                ST_ADD: begin
                    if (!w_over) begin
                        r_credit <= w_sum[VAL_W-1:0];
                    end
                end
                ST_DISP: begin
                    r_credit <= r_credit - w_price;
                end
                ST_CHANGE: begin
                    r_credit <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-item stock. Restock overrides a same-cycle dispense decrement;
    // DISP is only reached with non-zero stock, so no underflow guard.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ITEMS; i++) begin
            if (rst || restock) begin
                r_stock[i] <= c_stock_init;
            end else if ((r_state == ST_DISP) && (r_sel == SEL_W'(i))) begin
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_ctrl
//  Purpose  : Self-checking bench for vend_ctrl. A cycle table covers the
//             basic purchase, hand sequences cover the corner cases, and a
//             randomized phase is checked against a transaction-level model
//             (credit, stock and price arrays updated with plain arithmetic).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    localparam int VAL_W   = 8;
    localparam int N_ITEMS = 4;
    localparam int SEL_W   = 2;
    localparam int S_INIT  = 2;
    localparam int MAXC    = 200;

    logic                     clk;
    logic                     rst;
    logic                     coin_valid;
    logic [VAL_W-1:0]         coin_val;
    logic                     sel_valid;
    logic [SEL_W-1:0]         sel;
    logic                     cancel;
    logic                     restock;
    logic [N_ITEMS*VAL_W-1:0] prices;
    logic [VAL_W-1:0]         credit;
    logic                     coin_rej;
    logic                     disp;
    logic [SEL_W-1:0]         disp_item;
    logic                     chg_valid;
    logic [VAL_W-1:0]         chg_amt;
    logic                     err_insuf;
    logic                     err_empty;
    logic [N_ITEMS-1:0]       sold_out;
    logic                     busy;

    vend_ctrl #(
        .VAL_W      (VAL_W),
        .N_ITEMS    (N_ITEMS),
        .SEL_W      (SEL_W),
        .STOCK_W    (4),
        .STOCK_INIT (S_INIT),
        .MAX_CREDIT (MAXC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin_valid (coin_valid),
        .coin_val   (coin_val),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .restock    (restock),
        .prices     (prices),
        .credit     (credit),
        .coin_rej   (coin_rej),
        .disp       (disp),
        .disp_item  (disp_item),
        .chg_valid  (chg_valid),
        .chg_amt    (chg_amt),
        .err_insuf  (err_insuf),
        .err_empty  (err_empty),
        .sold_out   (sold_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- model state ----------------
    int          m_credit;
    int          m_stock [N_ITEMS];
    logic [7:0]  m_price [N_ITEMS];

    // expected outcome of one transaction
    int e_disp, e_item, e_chg, e_amt, e_ins, e_emp, e_rej;
    // observed outcome of one transaction
    int a_disp, a_item, a_chg, a_amt, a_ins, a_emp, a_rej, a_badamt;

    typedef struct {
        logic       cv;
        logic [7:0] cval;
        logic       sv;
        logic [1:0] s;
        logic       cn;
        logic [7:0] e_credit;
        logic       e_busy;
        logic       e_rej;
        logic       e_disp;
        logic [1:0] e_item;
        logic       e_chg;
        logic [7:0] e_amt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic cv, input logic [7:0] cval, input logic sv,
                          input logic [1:0] s, input logic cn, input logic rs);
        coin_valid = cv;
        coin_val   = cval;
        sel_valid  = sv;
        sel        = s;
        cancel     = cn;
        restock    = rs;
    endtask

    task automatic apply_prices();
        prices = {m_price[3], m_price[2], m_price[1], m_price[0]};
    endtask

    function automatic logic [N_ITEMS-1:0] model_sold_out();
        logic [N_ITEMS-1:0] b;
        for (int i = 0; i < N_ITEMS; i++) b[i] = (m_stock[i] == 0);
        return b;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < N_ITEMS; i++) m_stock[i] = S_INIT;
    endtask

    task automatic exp_clear();
        e_disp = 0; e_item = 0; e_chg = 0; e_amt = 0; e_ins = 0; e_emp = 0; e_rej = 0;
    endtask

    task automatic model_coin(input int v);
        exp_clear();
        if (m_credit + v > MAXC) e_rej = 1;
        else m_credit = m_credit + v;
    endtask

    task automatic model_cancel();
        exp_clear();
        if (m_credit > 0) begin
            e_chg = 1; e_amt = m_credit;
        end
        m_credit = 0;
    endtask

    task automatic model_sel(input int s);
        exp_clear();
        if (m_stock[s] == 0) begin
            e_emp = 1;
        end else if (m_credit < int'(m_price[s])) begin
            e_ins = 1;
        end else begin
            e_disp = 1;
            e_item = s;
            m_stock[s] = m_stock[s] - 1;
            m_credit = m_credit - int'(m_price[s]);
            if (m_credit > 0) begin
                e_chg = 1; e_amt = m_credit;
            end
            m_credit = 0;
        end
    endtask

    task automatic model_restock();
        exp_clear();
        for (int i = 0; i < N_ITEMS; i++) m_stock[i] = S_INIT;
    endtask

    task automatic acc();
        a_disp += int'(disp);
        if (disp) a_item = int'(disp_item);
        a_chg += int'(chg_valid);
        if (chg_valid) a_amt += int'(chg_amt);
        else if (chg_amt != '0) a_badamt++;
        a_ins += int'(err_insuf);
        a_emp += int'(err_empty);
        a_rej += int'(coin_rej);
    endtask

    // Drives one request from WAIT and observes until the controller is idle
    // again. lc: coin arrives the cycle after the request; lr: restock pulse
    // two cycles after the request (the DISP cycle of a successful purchase).
    task automatic txn(input logic cv, input logic [7:0] cval, input logic sv,
                       input logic [1:0] s, input logic cn, input logic rs,
                       input logic lc, input logic lr, input string tag);
        bit done = 0;
        a_disp = 0; a_item = 0; a_chg = 0; a_amt = 0; a_ins = 0; a_emp = 0; a_rej = 0; a_badamt = 0;
        set_in(cv, cval, sv, s, cn, rs);
        #1;
        acc();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            set_in(lc && (k == 0), 8'd10, 1'b0, 2'd0, 1'b0, lr && (k == 1));
            #1;
            acc();
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        chk({tag, "_disp"},   a_disp, e_disp);
        if (e_disp != 0) chk({tag, "_item"}, a_item, e_item);
        chk({tag, "_chg"},    a_chg,  e_chg);
        chk({tag, "_amt"},    a_amt,  e_amt);
        chk({tag, "_badamt"}, a_badamt, 0);
        chk({tag, "_insuf"},  a_ins,  e_ins);
        chk({tag, "_empty"},  a_emp,  e_emp);
        chk({tag, "_rej"},    a_rej,  e_rej);
        chk({tag, "_credit"}, credit, m_credit);
        chk({tag, "_soldout"}, sold_out, model_sold_out());
    endtask

    task automatic op_coin(input int v);
        model_coin(v);
        txn(1'b1, 8'(v), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, "coin");
    endtask

    task automatic op_sel(input int s);
        model_sel(s);
        txn(1'b0, 8'd0, 1'b1, 2'(s), 1'b0, 1'b0, 1'b0, 1'b0, "sel");
    endtask

    task automatic op_cancel();
        model_cancel();
        txn(1'b0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "cancel");
    endtask

    task automatic op_restock();
        model_restock();
        txn(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, "restock");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        m_price[0] = 8'd75; m_price[1] = 8'd50; m_price[2] = 8'd25; m_price[3] = 8'd0;
        apply_prices();

        // ---------------- reset ----------------
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy_init", busy, 1);
        chk("rst_credit",    credit, 0);
        chk("rst_soldout",   sold_out, 0);
        chk("rst_disp",      disp, 0);
        chk("rst_chg_amt",   chg_amt, 0);
        @(negedge clk);
        #1;
        chk("rst_busy_wait", busy, 0);
        model_reset();

        // ---------------- table: three coins then buy item 1 ----------------
        //            cv  cval   sv s    cn  credit busy rej disp item chg amt
        tbl[0]  = '{1'b1, 8'd25, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 8'd25, 1'b0, 2'd0, 1'b0, 8'd25, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd25, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 8'd25, 1'b0, 2'd0, 1'b0, 8'd50, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd50, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 8'd0,  1'b1, 2'd1, 1'b0, 8'd75, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd75, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd75, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd25, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 8'd25};
        tbl[10] = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 8'd0,  1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'd0};
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].cv, tbl[i].cval, tbl[i].sv, tbl[i].s, tbl[i].cn, 1'b0);
            #1;
            chk($sformatf("tbl%0d_credit", i), credit,    tbl[i].e_credit);
            chk($sformatf("tbl%0d_busy", i),   busy,      tbl[i].e_busy);
            chk($sformatf("tbl%0d_rej", i),    coin_rej,  tbl[i].e_rej);
            chk($sformatf("tbl%0d_disp", i),   disp,      tbl[i].e_disp);
            chk($sformatf("tbl%0d_item", i),   disp_item, tbl[i].e_item);
            chk($sformatf("tbl%0d_chg", i),    chg_valid, tbl[i].e_chg);
            chk($sformatf("tbl%0d_amt", i),    chg_amt,   tbl[i].e_amt);
            chk($sformatf("tbl%0d_errs", i),   {err_insuf, err_empty}, 2'b00);
            @(negedge clk);
        end
        m_stock[1] = m_stock[1] - 1;
        set_in(0, 0, 0, 0, 0, 0);

        // ---------------- credit ceiling ----------------
        op_cancel();                 // credit 0: no pulse
        op_coin(100);
        op_coin(90);                 // 190
        op_coin(25);                 // 215 > 200: rejected
        op_coin(10);                 // exactly 200: accepted
        op_cancel();
        op_coin(100);
        op_coin(90);
        // buy item 0 while a coin arrives during CHECK: bounced, not credited
        model_sel(0);
        e_rej = 1;
        txn(1'b0, 8'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, "sel_latecoin");

        // ---------------- insufficient / cancel / free item ----------------
        op_coin(25);
        op_sel(0);                   // price 75 > 25
        op_cancel();                 // change 25
        op_cancel();                 // nothing
        op_sel(3);                   // free item with zero credit
        // cancel and coin together: cancel wins, coin dropped
        op_coin(30);
        model_cancel();
        txn(1'b1, 8'd40, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, "cancel_prio");

        // ---------------- sold out and restock ----------------
        op_restock();
        op_coin(25); op_sel(2);
        op_coin(25); op_sel(2);      // stock[2] now 0
        op_coin(25); op_sel(2);      // err_empty
        op_restock();
        op_cancel();

        // ---------------- restock during DISP ----------------
        op_coin(25);
        model_sel(2);
        model_restock();
        e_disp = 1; e_item = 2;
        txn(1'b0, 8'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, "sel_restock");
        op_coin(25); op_sel(2);      // stock 2 -> 1, not sold out
        op_coin(25); op_sel(2);      // 1 -> 0

        // ---------------- reset during CHANGE ----------------
        op_coin(50);
        set_in(0, 0, 0, 0, 1, 0);
        #1;
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("rchg_pulse", {chg_valid, chg_amt}, {1'b1, 8'd50});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rchg_after1", {chg_valid, credit}, {1'b0, 8'd0});
        @(negedge clk);
        #1;
        chk("rchg_after2", {chg_valid, busy, credit}, {1'b0, 1'b0, 8'd0});
        model_reset();

        // ---------------- reset during DISP ----------------
        op_coin(100);
        set_in(0, 0, 1, 2'd2, 0, 0);
        #1;
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("rdisp_check", {err_insuf, err_empty, busy}, 3'b001);
        @(negedge clk);
        #1;
        chk("rdisp_disp", {disp, disp_item}, {1'b1, 2'd2});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdisp_after1", {chg_valid, credit}, {1'b0, 8'd0});
        @(negedge clk);
        #1;
        chk("rdisp_after2", {chg_valid, busy, credit, sold_out}, {1'b0, 1'b0, 8'd0, 4'b0000});
        model_reset();

        // ---------------- randomized against the model ----------------
        for (int n = 0; n < 200; n++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 8) begin
                if ($urandom_range(0, 3) == 0) op_coin(int'($urandom_range(150, 255)));
                else op_coin(int'($urandom_range(0, 100)));
            end else if (r < 14) begin
                op_sel(int'($urandom_range(0, 3)));
            end else if (r < 16) begin
                op_cancel();
            end else if (r < 17) begin
                op_restock();
            end else begin
                for (int i = 0; i < N_ITEMS; i++) begin
                    if ($urandom_range(0, 3) == 0) m_price[i] = 8'd0;
                    else m_price[i] = 8'($urandom_range(1, 150));
                end
                apply_prices();
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
